// File: rtl/limb_rio_uart_tx.sv
// limb_rio_uart_tx: buffers bytes from the CPU's rio_out in a small FIFO and sends each one as an 8N1 UART frame on tx
//   clk/reset: rising-edge clock, synchronous active-high reset
//   data/valid/ready: byte push handshake; a push happens on edges where valid && ready
//   tx: serial line, idle high; busy: frame in flight or FIFO non-empty; count: FIFO occupancy
module limb_rio_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [7:0]                         data,
  input  logic                               valid,
  output logic                               ready,
  output logic                               tx,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [7:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [BW-1:0] baud, baud_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shift, shift_n;
  logic tx_n, push, pop, baud_end;
  assign ready = count != CW'(FIFO_DEPTH);
  assign busy = state != IDLE || count != '0;
  assign push = valid && ready;
  assign baud_end = baud == BW'(CLKS_PER_BIT-1);
  // pop uses registered count, so a byte always spends at least one edge in the FIFO
  assign pop = count != '0 && (state == IDLE || (state == STOP && baud_end));
  always_comb begin
    state_n = state;
    baud_n = baud_end ? '0 : baud + 1'b1;
    bit_idx_n = bit_idx;
    shift_n = shift;
    tx_n = tx;
    if (pop) begin
      state_n = START;
      shift_n = mem[rd_ptr];
      tx_n = 1'b0;
      baud_n = '0;
    end else if (state == IDLE) begin
      baud_n = '0;
    end else if (baud_end) begin
      case (state)
        START: begin
          state_n = DATA;
          bit_idx_n = '0;
          tx_n = shift[0];
          shift_n = shift >> 1;
        end
        DATA: begin
          state_n = bit_idx == 3'd7 ? STOP : DATA;
          bit_idx_n = bit_idx + 1'b1;
          tx_n = bit_idx == 3'd7 ? 1'b1 : shift[0];
          shift_n = shift >> 1;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      baud <= '0;
      bit_idx <= '0;
      shift <= '0;
      tx <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      baud <= baud_n;
      bit_idx <= bit_idx_n;
      shift <= shift_n;
      tx <= tx_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end
endmodule

// File: tb/tb_limb_rio_uart_tx.sv
// tb_limb_rio_uart_tx: randomized and directed checks of the UART transmitter against a queue/frame-timer model
module tb_limb_rio_uart_tx;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  logic clk = 1'b0;
  logic reset, valid, ready, tx, busy;
  logic [7:0] data;
  logic [2:0] count;
  int total = 0;
  int bad = 0;
  int fpos = -1;
  logic [9:0] frame;
  logic [7:0] q[$];
  logic [9:0] pat_a5;
  always #5 clk = ~clk;
  limb_rio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .data(data), .valid(valid),
    .ready(ready), .tx(tx), .busy(busy), .count(count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // One clock: drive inputs, advance the model by one edge, compare all outputs away from the edge.
  // Model: FIFO is a queue; a frame is 10 bits {stop, byte, start} sent LSB first, CPB cycles each.
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    logic full, start;
    logic [7:0] b;
    valid = v;
    data = d;
    reset = r;
    @(posedge clk);
    full = q.size() == DEPTH;
    start = (fpos < 0 || fpos == FRAME - 1) && q.size() != 0;
    if (fpos >= 0) fpos = (fpos == FRAME - 1) ? -1 : fpos + 1;
    if (start) begin
      b = q.pop_front();
      frame = {1'b1, b, 1'b0};
      fpos = 0;
    end
    if (v && !full) q.push_back(d);
    if (r) begin
      q.delete();
      fpos = -1;
    end
    @(negedge clk);
    check("tx", tx, fpos < 0 ? 1 : frame[fpos / CPB]);
    check("busy", busy, fpos >= 0 || q.size() != 0);
    check("count", count, q.size());
    check("ready", ready, q.size() != DEPTH);
  endtask
  initial begin
    valid = 1'b0;
    data = 8'h00;
    reset = 1'b1;
    pat_a5 = 10'b1101001010;
    @(negedge clk);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 1);
    check("rst_count", count, 0);
    for (int i = 0; i < 100; i++) step(1'b0, 8'($urandom), 1'b0);
    check("idle_tx", tx, 1);
    check("idle_busy", busy, 0);
    // single byte 0xA5: start, LSB-first data, stop, each held CPB cycles
    step(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 8'($urandom), 1'b0);
      check("a5_bit", tx, pat_a5[i / CPB]);
    end
    step(1'b0, 8'h00, 1'b0);
    check("a5_done_busy", busy, 0);
    // burst of five into an idle FIFO, then a sixth push while full
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0);
    check("burst_count", count, 4);
    check("burst_ready", ready, 0);
    step(1'b1, 8'h06, 1'b0);
    check("full_drop", count, 4);
    for (int i = 0; i < 5 * FRAME + 10; i++) step(1'b0, 8'($urandom), 1'b0);
    check("burst_drain", busy, 0);
    // simultaneous push and pop with count=2
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    for (int i = 0; i < FRAME - 2; i++) step(1'b0, 8'($urandom), 1'b0);
    check("pp_before", count, 2);
    step(1'b1, 8'h44, 1'b0);
    check("pp_count", count, 2);
    for (int i = 0; i < 6; i++) step(1'b1, 8'h50 + 8'(i), 1'b0);
    for (int i = 0; i < 6 * FRAME; i++) step(1'b0, 8'($urandom), 1'b0);
    // valid held with changing data while full
    for (int i = 0; i < 300; i++) step(1'b1, 8'($urandom), 1'b0);
    // random traffic
    for (int i = 0; i < 1500; i++) step($urandom_range(0, 5) == 0, 8'($urandom), 1'b0);
    for (int i = 0; i < DEPTH * FRAME + FRAME; i++) step(1'b0, 8'($urandom), 1'b0);
    // reset during data bit 3 of 0xFF
    step(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 18; i++) step(1'b0, 8'($urandom), 1'b0);
    check("pre_rst_busy", busy, 1);
    step(1'b0, 8'h00, 1'b1);
    check("mid_rst_tx", tx, 1);
    check("mid_rst_count", count, 0);
    check("mid_rst_busy", busy, 0);
    step(1'b1, 8'h3C, 1'b0);
    for (int i = 0; i < FRAME + 5; i++) step(1'b0, 8'($urandom), 1'b0);
    check("end_busy", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
